// File: rtl/cpu_pkg.sv
// ------------------------------------------------------------------
// Package : cpu_pkg
// Desc    : Shared widths, opcode fields and prefetch state encoding.
// Rev     : 1.0 - initial release
// ------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int WIDTH    = 32;
  localparam int ADDRSIZE = 12;

  localparam int          OPC_MSB = 31;
  localparam int          OPC_LSB = 28;
  localparam logic [3:0]  OP_HLT  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } pf_state_e;

endpackage

`default_nettype wire

// File: rtl/ins_fifo.sv
// ------------------------------------------------------------------
// Module : ins_fifo
// Desc   : Synchronous FIFO with a registered head stage and flush.
// Rev    : 1.0 - initial release
// ------------------------------------------------------------------
`default_nettype none

module ins_fifo #(
  parameter int DW    = 44,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [DW-1:0] din_i,
  output logic          head_valid_o,
  output logic [DW-1:0] head_o,
  output logic [LW-1:0] level_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic          head_valid_q;
  logic [DW-1:0] head_q;
  logic [LW-1:0] mem_cnt_d;
  logic          load_d;

  // level counts the head slot too; entries still in the array feed the head
  assign mem_cnt_d = level_q - LW'(head_valid_q);
  assign load_d    = (mem_cnt_d != '0) && (!head_valid_q || pop_i);

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q         <= '0;
      rd_q         <= '0;
      level_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else if (clear_i) begin
      wr_q         <= '0;
      rd_q         <= '0;
      level_q      <= '0;
      head_valid_q <= 1'b0;
    end else begin
      if (push_i) begin
        wr_q <= wr_q + PW'(1);
      end
      if (load_d) begin
        head_q       <= mem_q[rd_q];
        rd_q         <= rd_q + PW'(1);
        head_valid_q <= 1'b1;
      end else if (pop_i) begin
        head_valid_q <= 1'b0;
      end
      level_q <= level_q + LW'(push_i) - LW'(pop_i);
    end
  end

  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;
  assign level_o      = level_q;

endmodule

`default_nettype wire

// File: rtl/instruction_prefetch_unit.sv
// ------------------------------------------------------------------
// Module : instruction_prefetch_unit
// Desc   : Fetch PC, memory request FSM and instruction buffer.
//          Optional HLT stop compiled in with IPU_HALT_STOP_EN.
// Rev    : 1.0 - initial release
// ------------------------------------------------------------------
`default_nettype none

module instruction_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH    = cpu_pkg::WIDTH,
  parameter int ADDRSIZE = cpu_pkg::ADDRSIZE,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDRSIZE-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [WIDTH-1:0]       imem_rdata,
  output logic                   ins_valid,
  output logic [WIDTH-1:0]       ins_data,
  output logic [ADDRSIZE-1:0]    ins_pc,
  input  logic                   ins_ready,
  input  logic                   redirect,
  input  logic [ADDRSIZE-1:0]    redirect_pc,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int LW = $clog2(DEPTH) + 1;

  pf_state_e             state_q;
  logic                  req_q;
  logic [ADDRSIZE-1:0]   addr_q, pc_q, pc_inc_d;
  logic                  pop_d, push_d;
  logic [LW-1:0]         level_d, lvl_pop_d, lvl_after_d;
  logic [ADDRSIZE+WIDTH-1:0] head_d;

  // redirect outranks both buffer ports; acks in DRAIN are simply dropped
  assign pop_d       = ins_valid && ins_ready && !redirect;
  assign push_d      = (state_q == ST_REQ) && imem_ack && !redirect;
  assign lvl_pop_d   = level_d - LW'(pop_d);
  assign lvl_after_d = lvl_pop_d + LW'(push_d);
  assign pc_inc_d    = pc_q + ADDRSIZE'(1);

`ifdef IPU_HALT_STOP_EN
  logic is_hlt_d;
  assign is_hlt_d = (imem_rdata[OPC_MSB:OPC_LSB] == OP_HLT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      pc_q    <= ADDRSIZE'(RESET_PC);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            addr_q  <= redirect_pc;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end else if (lvl_pop_d < LW'(DEPTH)) begin
            addr_q  <= pc_q;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (redirect) begin
            pc_q <= redirect_pc;
            if (imem_ack) addr_q  <= redirect_pc;
            else          state_q <= ST_DRAIN;
          end else if (imem_ack) begin
            pc_q <= pc_inc_d;
`ifdef IPU_HALT_STOP_EN
            if (is_hlt_d) begin
              req_q   <= 1'b0;
              state_q <= ST_HALT;
            end else
`endif
            if (lvl_after_d < LW'(DEPTH)) begin
              addr_q <= pc_inc_d;
            end else begin
              req_q   <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (redirect) pc_q <= redirect_pc;
          if (imem_ack) begin
            addr_q  <= redirect ? redirect_pc : pc_q;
            state_q <= ST_REQ;
          end
        end
`ifdef IPU_HALT_STOP_EN
        ST_HALT: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            addr_q  <= redirect_pc;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
`endif
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  ins_fifo #(
    .DW    (ADDRSIZE + WIDTH),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_d),
    .pop_i        (pop_d),
    .clear_i      (redirect),
    .din_i        ({pc_q, imem_rdata}),
    .head_valid_o (ins_valid),
    .head_o       (head_d),
    .level_o      (level_d)
  );

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ins_pc     = head_d[ADDRSIZE+WIDTH-1:WIDTH];
  assign ins_data   = head_d[WIDTH-1:0];
  assign fifo_level = level_d;

endmodule

`default_nettype wire

// File: tb/tb_instruction_prefetch_unit.sv
// ------------------------------------------------------------------
// Module : tb_instruction_prefetch_unit
// Desc   : Directed bench for instruction_prefetch_unit with a memory model.
// Rev    : 1.0 - initial release
// ------------------------------------------------------------------
`default_nettype none

module tb_instruction_prefetch_unit;

  localparam int W = 32;
  localparam int A = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [A-1:0]  imem_addr;
  logic          imem_ack = 1'b0;
  logic [W-1:0]  imem_rdata = '0;
  logic          ins_valid;
  logic [W-1:0]  ins_data;
  logic [A-1:0]  ins_pc;
  logic          ins_ready = 1'b0;
  logic          redirect = 1'b0;
  logic [A-1:0]  redirect_pc = '0;
  logic [2:0]    fifo_level;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_wait = 0;
  int wcnt = 0;
  bit hlt_word_en = 1'b0;
  logic [A-1:0] aq[$];   // addresses of acked requests
  logic [A-1:0] pq[$];   // pcs consumed by the core

  instruction_prefetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc),
    .ins_ready(ins_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word_at(input logic [A-1:0] a);
    if (hlt_word_en && a == 12'd2) return 32'h9000_0000;
    return 32'hA500_0000 | {20'd0, a};
  endfunction

  // memory with configurable wait states, plus stream monitors
  always @(negedge clk) begin
    if (rst) begin
      wcnt     = 0;
      imem_ack = 1'b0;
    end else begin
      if (imem_ack) wcnt = 0;
      if (imem_req && wcnt >= ack_wait) imem_ack = 1'b1;
      else begin
        imem_ack = 1'b0;
        if (imem_req) wcnt++;
      end
    end
    imem_rdata = word_at(imem_addr);
    if (!rst && imem_req && imem_ack) aq.push_back(imem_addr);
    if (!rst && ins_valid && ins_ready && !redirect) pq.push_back(ins_pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; ins_ready = 1'b0;
    repeat (3) tick();
    aq.delete(); pq.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", imem_req); end
    n_tests++; if (imem_addr !== 12'h000) begin n_fail++; $display("FAIL rst_addr got %h want 000", imem_addr); end
    n_tests++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", ins_valid); end
    n_tests++; if (ins_data !== 32'h0) begin n_fail++; $display("FAIL rst_data got %h want 0", ins_data); end
    n_tests++; if (ins_pc !== 12'h000) begin n_fail++; $display("FAIL rst_pc got %h want 000", ins_pc); end
    n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_reset();
    ack_wait = 0; ins_ready = 1'b1;
    tick();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 12'h000 || ins_valid !== 1'b0) begin
      n_fail++; $display("FAIL zw_first_req got req=%b addr=%h v=%b want 1/000/0", imem_req, imem_addr, ins_valid); end
    tick();
    n_tests++; if (imem_addr !== 12'h001 || fifo_level !== 3'd1 || ins_valid !== 1'b0) begin
      n_fail++; $display("FAIL zw_second got addr=%h lvl=%0d v=%b want 001/1/0", imem_addr, fifo_level, ins_valid); end
    tick();
    n_tests++; if (ins_valid !== 1'b1 || ins_pc !== 12'h000 || ins_data !== 32'hA500_0000) begin
      n_fail++; $display("FAIL zw_latency got v=%b pc=%h d=%h want 1/000/a5000000", ins_valid, ins_pc, ins_data); end
    repeat (10) tick();
    n_tests++; if (pq.size() < 8 || aq.size() < 8) begin
      n_fail++; $display("FAIL zw_count got pops=%0d acks=%0d want >=8", pq.size(), aq.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++; if (pq[i] !== A'(i) || aq[i] !== A'(i)) begin
          n_fail++; $display("FAIL zw_seq[%0d] got pc=%h addr=%h want %h", i, pq[i], aq[i], A'(i)); end
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    ack_wait = 0; ins_ready = 1'b0;
    repeat (10) tick();
    n_tests++; if (fifo_level !== 3'd4 || imem_req !== 1'b0 || aq.size() != 4) begin
      n_fail++; $display("FAIL full_state got lvl=%0d req=%b acks=%0d want 4/0/4", fifo_level, imem_req, aq.size()); end
    n_tests++; if (ins_valid !== 1'b1 || ins_pc !== 12'h000) begin
      n_fail++; $display("FAIL full_head got v=%b pc=%h want 1/000", ins_valid, ins_pc); end
    ins_ready = 1'b1;
    repeat (20) tick();
    n_tests++; if (pq.size() < 12) begin
      n_fail++; $display("FAIL full_drain got pops=%0d want >=12", pq.size()); end
    else begin
      for (int i = 0; i < 12; i++) begin
        n_tests++; if (pq[i] !== A'(i)) begin
          n_fail++; $display("FAIL full_seq[%0d] got %h want %h", i, pq[i], A'(i)); end
      end
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    ack_wait = 3; ins_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 12'h100;
    tick();
    redirect = 1'b0; redirect_pc = 12'h3FF;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin
      n_fail++; $display("FAIL drain_hold got req=%b addr=%h want 1/000", imem_req, imem_addr); end
    repeat (2) tick();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 12'h000 || ins_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_hold2 got req=%b addr=%h v=%b want 1/000/0", imem_req, imem_addr, ins_valid); end
    repeat (20) tick();
    n_tests++; if (aq.size() < 2 || pq.size() < 1) begin
      n_fail++; $display("FAIL drain_count got acks=%0d pops=%0d want >=2/>=1", aq.size(), pq.size()); end
    else begin
      n_tests++; if (aq[0] !== 12'h000 || aq[1] !== 12'h100) begin
        n_fail++; $display("FAIL drain_addr got %h,%h want 000,100", aq[0], aq[1]); end
      n_tests++; if (pq[0] !== 12'h100) begin
        n_fail++; $display("FAIL drain_first_pc got %h want 100", pq[0]); end
    end
    ack_wait = 0;
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    ack_wait = 0; ins_ready = 1'b1;
    repeat (6) tick();
    n_tests++; if (ins_valid !== 1'b1 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL rap_pre got v=%b req=%b want 1/1", ins_valid, imem_req); end
    pq.delete();
    redirect = 1'b1; redirect_pc = 12'h020;
    tick();
    redirect = 1'b0; redirect_pc = 12'h000;
    n_tests++; if (ins_valid !== 1'b0 || imem_addr !== 12'h020 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL rap_flush got v=%b addr=%h req=%b want 0/020/1", ins_valid, imem_addr, imem_req); end
    repeat (10) tick();
    n_tests++; if (pq.size() < 3) begin
      n_fail++; $display("FAIL rap_count got %0d want >=3", pq.size()); end
    else begin
      n_tests++; if (pq[0] !== 12'h020 || pq[1] !== 12'h021 || pq[2] !== 12'h022) begin
        n_fail++; $display("FAIL rap_seq got %h,%h,%h want 020,021,022", pq[0], pq[1], pq[2]); end
    end
  endtask

  task automatic test_wrap();
    pq.delete();
    redirect = 1'b1; redirect_pc = 12'hFFE;
    tick();
    redirect = 1'b0;
    repeat (10) tick();
    n_tests++; if (pq.size() < 4) begin
      n_fail++; $display("FAIL wrap_count got %0d want >=4", pq.size()); end
    else begin
      n_tests++; if (pq[0] !== 12'hFFE || pq[1] !== 12'hFFF || pq[2] !== 12'h000 || pq[3] !== 12'h001) begin
        n_fail++; $display("FAIL wrap_seq got %h,%h,%h,%h want ffe,fff,000,001", pq[0], pq[1], pq[2], pq[3]); end
    end
  endtask

  task automatic test_hlt_word();
    hlt_word_en = 1'b1;
    do_reset();
    ack_wait = 0; ins_ready = 1'b1;
    repeat (12) tick();
`ifdef IPU_HALT_STOP_EN
    n_tests++; if (aq.size() != 3 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL halt_stop got acks=%0d req=%b want 3/0", aq.size(), imem_req); end
    n_tests++; if (pq.size() != 3 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL halt_drain got pops=%0d lvl=%0d want 3/0", pq.size(), fifo_level); end
    redirect = 1'b1; redirect_pc = 12'h010;
    tick();
    redirect = 1'b0;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 12'h010) begin
      n_fail++; $display("FAIL halt_resume got req=%b addr=%h want 1/010", imem_req, imem_addr); end
    repeat (4) tick();
    n_tests++; if (aq.size() < 5 || aq[3] !== 12'h010 || aq[4] !== 12'h011) begin
      n_fail++; $display("FAIL halt_resume_seq got %0d acks want 010,011 after halt", aq.size()); end
`else
    n_tests++; if (aq.size() < 8 || imem_req !== 1'b1 || aq[3] !== 12'h003) begin
      n_fail++; $display("FAIL hlt_ignored got acks=%0d req=%b want >=8/1", aq.size(), imem_req); end
`endif
    hlt_word_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_reset();
    test_full();
    test_redirect_drain();
    test_redirect_ack_pop();
    test_wrap();
    test_hlt_word();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_prefetch_unit.md
Name: instruction_prefetch_unit

Overview:
- Upstream stage of the CPU core: fetches 32-bit instruction words from instruction memory and buffers them in a small FIFO.
- Presents the buffered words to the core's instruction register with a valid/ready handshake.
- Owns the fetch PC, so the core never drives instruction memory directly.
- A branch taken in the core arrives as a redirect; the unit then flushes its buffer and restarts fetching at the target.

Parameters:
- WIDTH, 32, instruction word width.
- ADDRSIZE, 12, instruction address width; the fetch PC wraps modulo 2^ADDRSIZE.
- DEPTH, 4, FIFO entries (power of two, at least 2).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDRSIZE  fetch address; stable while imem_req=1.
- imem_ack  in  1  memory accepts and completes the current request; imem_rdata is valid this cycle.
- imem_rdata  in  WIDTH  instruction word returned with imem_ack.
- ins_valid  out  1  FIFO head holds a valid instruction.
- ins_data  out  WIDTH  FIFO head instruction.
- ins_pc  out  ADDRSIZE  address of ins_data.
- ins_ready  in  1  core consumes the head this cycle when ins_valid=1.
- redirect  in  1  flush request from the core (taken branch).
- redirect_pc  in  ADDRSIZE  new fetch address, sampled when redirect=1.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy (debug).

Behaviour:
- Reset (rst=1 at a rising edge):
  - Outputs: imem_req=0, imem_addr=0, ins_valid=0, ins_data=0, ins_pc=0, fifo_level=0.
  - Internal: fetch_pc=RESET_PC, state=IDLE, FIFO empty.
  - Reset mid-request abandons the request; the memory must also be reset.
- States:
  - IDLE: no request outstanding.
  - REQ: imem_req=1, imem_addr=fetch_pc.
  - DRAIN: stale request still outstanding after a redirect.
  - HALT: only when the optional feature is compiled in.
- Request rule: imem_req and imem_addr are registered. Once imem_req=1 it stays 1 with a constant address until imem_ack; there is no cancellation. At most one request is outstanding.
- IDLE -> REQ when fifo_level < DEPTH after this cycle's pop, and no redirect is present. The first request is visible the cycle after the first edge with rst=0.
- REQ with imem_ack:
  - Push {fetch_pc, imem_rdata}; fetch_pc <= fetch_pc+1, wrapping 4095 -> 0.
  - Stay in REQ with the new address if occupancy after push and pop is < DEPTH; otherwise go to IDLE.
  - A zero-wait memory therefore sustains one word per cycle.
- Pop when ins_valid && ins_ready. A push and a pop in the same cycle leave the level unchanged.
- Full FIFO: no new request is issued. A request already issued always has a reserved slot, so a push never overflows.
- Empty FIFO: ins_valid=0, and ins_data/ins_pc hold their last values.
- Latency: an ack at edge N gives ins_valid=1 after edge N+1 at the earliest (registered FIFO output).
- Redirect has highest priority over push and pop:
  - FIFO cleared (ins_valid=0 the next cycle) and fetch_pc <= redirect_pc.
  - If a request is outstanding without ack this cycle: go to DRAIN. imem_req stays on the old address until ack; that response is discarded; then go to REQ at redirect_pc.
  - If imem_ack arrives in the same cycle: the response is discarded and the unit goes to REQ at redirect_pc.
  - Redirect in IDLE: go to REQ at redirect_pc.
  - Redirect during DRAIN: only the target is updated; drain continues.
- Any pop coincident with redirect is ignored; the core treats the word as consumed.

Optional Feature:
- Macro: IPU_HALT_STOP_EN.
- Defined: when a pushed word has bits [31:28]=4'b1001 (HLT), go to HALT after that ack. HALT issues no further requests; buffered words still drain to the core. Only redirect or rst leaves HALT.
- Undefined: the HALT state does not exist and prefetch continues past HLT words.

Decomposition:
- Package cpu_pkg holds:
  - WIDTH, ADDRSIZE, OPCODE field position [31:28] and OP_HLT=4'b1001.
  - The prefetch state encoding (IDLE/REQ/DRAIN/HALT).
- Sub-module ins_fifo: synchronous FIFO of {ADDRSIZE+WIDTH} bits with push, pop, clear, level, and a registered head.
- The top level holds the FSM and fetch_pc.

Test Plan:
- Reset, zero-wait memory (ack every cycle while req), ins_ready=1 -> ins_pc sequence 0,1,2,3… one per cycle; imem_addr increments each cycle.
- ins_ready=0, ack always -> exactly 4 words buffered, fifo_level=4, imem_req=0. Raise ins_ready -> pcs 0..3 then 4 onward, no gaps or duplicates.
- Ack delayed 3 cycles; redirect to 12'h100 in the first wait cycle -> old address held until ack, old word dropped, next imem_addr=12'h100, first ins_pc=12'h100.
- Redirect to 12'h020 coincident with ack and pop -> no word from the old stream appears; next ins_pc=12'h020.
- Start at fetch_pc=12'hFFE -> ins_pc sequence FFE, FFF, 000, 001.
- IPU_HALT_STOP_EN defined, word at address 2 = 32'h9000_0000 -> no request after address 2 acks. Redirect to 12'h010 -> fetching resumes at 12'h010.
